// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_if
// Brief    : Handshake and serial-line bundle between a UART transmitter and
//            the logic that feeds it (tick strobe, request, payload, status).
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
  parameter int NB_DATA = 32
);
  logic               i_tick;
  logic               i_tx_start;
  logic [NB_DATA-1:0] i_data;
  logic               o_tx;
  logic               o_busy;
  logic               o_txdone;

  // Feeder side: drives the strobe, request and payload; observes status.
  modport master (
    output i_tick, i_tx_start, i_data,
    input  o_tx, o_busy, o_txdone
  );

  // Transmitter side.
  modport slave (
    input  i_tick, i_tx_start, i_data,
    output o_tx, o_busy, o_txdone
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : Oversampled UART transmitter. One start bit, NB_DATA data bits
//            sent MSB first, stop period of NB_STOP ticks. Serial line is
//            driven straight from a flop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int NB_DATA       = 32,
  parameter int NB_STOP       = 16,
  parameter int NB_OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      i_rst_n,
  uart_tx_if.slave  tx_if
);

  localparam int c_MAX_TICKS = (NB_OVERSAMPLE > NB_STOP) ? NB_OVERSAMPLE : NB_STOP;
  localparam int c_CNT_W     = (c_MAX_TICKS > 1) ? $clog2(c_MAX_TICKS) : 1;
  localparam int c_IDX_W     = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [c_CNT_W-1:0] c_OS_LAST   = c_CNT_W'(NB_OVERSAMPLE - 1);
  localparam logic [c_CNT_W-1:0] c_STOP_LAST = c_CNT_W'(NB_STOP - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_MSB   = c_IDX_W'(NB_DATA - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q,   cnt_d;
  logic [c_IDX_W-1:0] idx_q,   idx_d;
  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic               tx_q,    tx_d;
  logic               done_q,  done_d;

  logic [c_IDX_W-1:0] w_idx_dec;

  // The payload is never shifted; bits are picked by index so the latched
  // word stays intact for the whole frame.
  assign w_idx_dec = idx_q - c_IDX_W'(1);

  // Next-state logic: counters only move on tick strobes, the line level is
  // precomputed so the flop updates exactly at each bit boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      c_IDLE: begin
        tx_d = 1'b1;
        if (tx_if.i_tx_start) begin
          shreg_d = tx_if.i_data;
          cnt_d   = '0;
          state_d = c_START;
          tx_d    = 1'b0;
        end
      end
      c_START: begin
        if (tx_if.i_tick) begin
          if (cnt_q == c_OS_LAST) begin
            cnt_d   = '0;
            idx_d   = c_IDX_MSB;
            state_d = c_DATA;
            tx_d    = shreg_q[c_IDX_MSB];
          end else begin
            cnt_d = cnt_q + c_CNT_W'(1);
          end
        end
      end
      c_DATA: begin
        if (tx_if.i_tick) begin
          if (cnt_q == c_OS_LAST) begin
            cnt_d = '0;
            if (idx_q == '0) begin
              state_d = c_STOP;
              tx_d    = 1'b1;
            end else begin
              idx_d = w_idx_dec;
              tx_d  = shreg_q[w_idx_dec];
            end
          end else begin
            cnt_d = cnt_q + c_CNT_W'(1);
          end
        end
      end
      default: begin
        // Stop period: line already high, just count it out.
        if (tx_if.i_tick) begin
          if (cnt_q == c_STOP_LAST) begin
            cnt_d   = '0;
            state_d = c_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + c_CNT_W'(1);
          end
        end
      end
    endcase
  end

  // State registers with asynchronous abort: line returns high immediately.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= c_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx_if.o_tx     = tx_q;
  assign tx_if.o_busy   = (state_q != c_IDLE);
  assign tx_if.o_txdone = done_q;

endmodule
`default_nettype wire
